// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: receiving end of an HD44780-style LCD bus.
// Latches each bus byte on the falling edge of lcd_en, decodes instructions,
// keeps DDRAM/CGRAM images and display-control state, and emulates the busy flag.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   lcd_rs/rw/en/data     controller-driven bus (lcd_en asynchronous to clk)
//   rd_sel, rd_addr       debug read target (0 DDRAM / 1 CGRAM) and address
//   rd_data               debug read data, 1-cycle latency
//   cmd_valid/byte/rs     one-cycle report of each accepted bus byte
//   addr_cnt, addr_is_cgram, display_on, cursor_on, blink_on,
//   entry_inc, two_line, eight_bit   controller-visible state
//   busy, err_busy, err_read         busy flag and sticky error flags
module lcd_bus_responder #(
  parameter int unsigned BUSY_CYCLES       = 40,
  parameter int unsigned CLEAR_BUSY_CYCLES = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic       rd_sel,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       cmd_rs,
  output logic [6:0] addr_cnt,
  output logic       addr_is_cgram,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       two_line,
  output logic       eight_bit,
  output logic       busy,
  output logic       err_busy,
  output logic       err_read
);

  localparam int unsigned CNT_MAX = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_EXEC, S_BUSY} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   busy_cnt, cnt_nx;
  logic [6:0]      fill_addr, fill_nx;
  logic [6:0]      addr_nx;
  logic            cg_nx, disp_nx, cur_nx, blink_nx, inc_nx, two_nx, eight_nx;
  logic            busy_nx, err_busy_nx, err_read_nx;
  logic            cmd_valid_nx, cmd_rs_nx;
  logic [7:0]      cmd_byte_nx;

  // Bus synchronizer: en_s3 is the previous value of the synchronized strobe.
  logic       en_s1, en_s2, en_s3;
  logic       rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0] data_s1, data_s2;
  logic       fall_c, long_c;

  // Display memories and their single write ports.
  logic [7:0] ddram [128];
  logic [7:0] cgram [64];
  logic       dd_we, cg_we;
  logic [6:0] dd_waddr;
  logic [5:0] cg_waddr;
  logic [7:0] dd_wdata, cg_wdata;

  // Address step with the display's line-window wrap rules.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up,
                                           input logic cg, input logic two);
    logic [6:0] r;
    r = up ? a + 7'd1 : a - 7'd1;
    if (cg) begin
      r = {1'b0, r[5:0]};
    end else if (two) begin
      if (up && a == 7'h27)       r = 7'h40;
      else if (up && a == 7'h67)  r = 7'h00;
      else if (!up && a == 7'h40) r = 7'h27;
      else if (!up && a == 7'h00) r = 7'h67;
    end else begin
      if (up && a == 7'h4F)       r = 7'h00;
      else if (!up && a == 7'h00) r = 7'h4F;
    end
    return r;
  endfunction

  // Strobe synchronizer with bus fields delayed to stay aligned with the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_s3   <= 1'b0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      rw_s1   <= 1'b0;
      rw_s2   <= 1'b0;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
    end else begin
      en_s1   <= lcd_en;
      en_s2   <= en_s1;
      en_s3   <= en_s2;
      rs_s1   <= lcd_rs;
      rs_s2   <= rs_s1;
      rw_s1   <= lcd_rw;
      rw_s2   <= rw_s1;
      data_s1 <= lcd_data;
      data_s2 <= data_s1;
    end
  end

  assign fall_c = en_s3 & ~en_s2;
  // Clear (0x01) and home (0x02/0x03) take the long busy time.
  assign long_c = ~rs_s2 & (data_s2[7:2] == 6'd0) & (data_s2[1:0] != 2'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FILL;
      busy_cnt      <= CW'(CLEAR_BUSY_CYCLES - 1);
      fill_addr     <= 7'd0;
      addr_cnt      <= 7'd0;
      addr_is_cgram <= 1'b0;
      display_on    <= 1'b0;
      cursor_on     <= 1'b0;
      blink_on      <= 1'b0;
      entry_inc     <= 1'b1;
      two_line      <= 1'b0;
      eight_bit     <= 1'b1;
      busy          <= 1'b1;
      err_busy      <= 1'b0;
      err_read      <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_byte      <= 8'h00;
      cmd_rs        <= 1'b0;
    end else begin
      state         <= state_nx;
      busy_cnt      <= cnt_nx;
      fill_addr     <= fill_nx;
      addr_cnt      <= addr_nx;
      addr_is_cgram <= cg_nx;
      display_on    <= disp_nx;
      cursor_on     <= cur_nx;
      blink_on      <= blink_nx;
      entry_inc     <= inc_nx;
      two_line      <= two_nx;
      eight_bit     <= eight_nx;
      busy          <= busy_nx;
      err_busy      <= err_busy_nx;
      err_read      <= err_read_nx;
      cmd_valid     <= cmd_valid_nx;
      cmd_byte      <= cmd_byte_nx;
      cmd_rs        <= cmd_rs_nx;
    end
  end

  // Next-state, decode and memory write control.
  always_comb begin
    state_nx     = state;
    cnt_nx       = (busy_cnt != '0) ? busy_cnt - CW'(1) : busy_cnt;
    fill_nx      = fill_addr;
    addr_nx      = addr_cnt;
    cg_nx        = addr_is_cgram;
    disp_nx      = display_on;
    cur_nx       = cursor_on;
    blink_nx     = blink_on;
    inc_nx       = entry_inc;
    two_nx       = two_line;
    eight_nx     = eight_bit;
    err_busy_nx  = err_busy;
    err_read_nx  = err_read;
    cmd_valid_nx = 1'b0;
    cmd_byte_nx  = cmd_byte;
    cmd_rs_nx    = cmd_rs;
    dd_we        = 1'b0;
    dd_waddr     = addr_cnt;
    dd_wdata     = cmd_byte;
    cg_we        = 1'b0;
    cg_waddr     = addr_cnt[5:0];
    cg_wdata     = cmd_byte;

    // Accept a byte only when idle; reads take priority in error reporting.
    if (fall_c) begin
      if (rw_s2) begin
        err_read_nx = 1'b1;
      end else if (state != S_IDLE) begin
        err_busy_nx = 1'b1;
      end else begin
        state_nx     = S_EXEC;
        cmd_valid_nx = 1'b1;
        cmd_byte_nx  = data_s2;
        cmd_rs_nx    = rs_s2;
        cnt_nx       = long_c ? CW'(CLEAR_BUSY_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
      end
    end

    case (state)
      S_FILL: begin
        dd_we    = 1'b1;
        dd_waddr = fill_addr;
        dd_wdata = 8'h20;
        fill_nx  = fill_addr + 7'd1;
        if (fill_addr == 7'h7F) state_nx = (busy_cnt == '0) ? S_IDLE : S_BUSY;
      end
      S_EXEC: begin
        state_nx = (busy_cnt == '0) ? S_IDLE : S_BUSY;
        if (cmd_rs) begin
          if (addr_is_cgram) cg_we = 1'b1;
          else               dd_we = 1'b1;
          addr_nx = step_addr(addr_cnt, entry_inc, addr_is_cgram, two_line);
        end else begin
          casez (cmd_byte)
            8'b1???????: begin addr_nx = cmd_byte[6:0]; cg_nx = 1'b0; end
            8'b01??????: begin addr_nx = {1'b0, cmd_byte[5:0]}; cg_nx = 1'b1; end
            8'b001?????: begin eight_nx = cmd_byte[4]; two_nx = cmd_byte[3]; end
            8'b0001????: begin
              if (!cmd_byte[3]) addr_nx = step_addr(addr_cnt, cmd_byte[2], addr_is_cgram, two_line);
            end
            8'b00001???: begin
              disp_nx  = cmd_byte[2];
              cur_nx   = cmd_byte[1];
              blink_nx = cmd_byte[0];
            end
            8'b000001??: inc_nx = cmd_byte[1];
            8'b0000001?: begin addr_nx = 7'd0; cg_nx = 1'b0; end
            8'b00000001: begin
              addr_nx  = 7'd0;
              cg_nx    = 1'b0;
              inc_nx   = 1'b1;
              fill_nx  = 7'd0;
              state_nx = S_FILL;
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (busy_cnt == '0) state_nx = S_IDLE;
      end
      default: ;
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

  // Memory write ports; held off during reset so a restart fills cleanly.
  always_ff @(posedge clk) begin
    if (dd_we && !reset) ddram[dd_waddr] <= dd_wdata;
    if (cg_we && !reset) cgram[cg_waddr] <= cg_wdata;
  end

  // Debug read port; a same-cycle write returns the old contents.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= rd_sel ? cgram[rd_addr[5:0]] : ddram[rd_addr];
  end

endmodule
